// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets NCORES pipelined cores share one single-ported data memory.
// It grants one access per cycle, tracks loads in flight through a tag pipe and drives each core's stall_num.
module mem_port_arbiter #(
  parameter int NCORES      = 2,
  parameter int MEM_LAT     = 2,
  parameter int STALL_STAGE = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORES-1:0]     req_rd,
  input  logic [NCORES-1:0]     req_wr,
  input  logic [NCORES*15-1:0]  req_addr,
  input  logic [NCORES*16-1:0]  req_wdata,
  output logic [NCORES*3-1:0]   stall_num,
  output logic [NCORES-1:0]     rsp_valid,
  output logic [NCORES*16-1:0]  rsp_data,
  output logic                  mem_ren,
  output logic [14:0]           mem_raddr,
  input  logic [15:0]           mem_rdata,
  output logic                  mem_wen,
  output logic [14:0]           mem_waddr,
  output logic [15:0]           mem_wdata
);

  localparam int IDW = (NCORES > 2) ? 2 : 1;
  localparam logic [2:0] STALL_V = 3'(STALL_STAGE);

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (int'(i) >= NCORES - 1) return '0;
    return i + 1'b1;
  endfunction

  logic [IDW-1:0]    rr_ptr;
  logic [NCORES-1:0] wr_done;
  logic              tag_vld_p [MEM_LAT];
  logic [IDW-1:0]    tag_id_p  [MEM_LAT];

  logic [NCORES-1:0] pending, want_wr, want, elig;
  logic              gnt_vld, gnt_wr, gnt_rd, rd_left, out_vld, served, hold;
  logic [IDW-1:0]    gnt_idx, cidx;
  logic [14:0]       sel_addr;
  logic [15:0]       sel_wdata;
  int                cand;

  // A core whose write half of a rd+wr pair was served ignores req_wr until its read is granted.
  always_comb begin
    pending = '0;
    for (int s = 0; s < MEM_LAT - 1; s++)
      if (tag_vld_p[s]) pending[tag_id_p[s]] = 1'b1;
    want_wr = req_wr & ~wr_done;
    want    = req_rd | want_wr;
    elig    = want & ~pending;

    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    cidx    = '0;
    for (int k = 0; k < NCORES; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NCORES) cand = cand - NCORES;
      cidx = IDW'(cand);
      if (!gnt_vld && elig[cidx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cidx;
      end
    end
    gnt_wr  = gnt_vld & want_wr[gnt_idx];
    gnt_rd  = gnt_vld & ~want_wr[gnt_idx];
    rd_left = gnt_wr & req_rd[gnt_idx];

    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORES; i++)
      if (IDW'(i) == gnt_idx) begin
        sel_addr  = req_addr[15*i +: 15];
        sel_wdata = req_wdata[16*i +: 16];
      end
  end

  always_comb begin
    mem_ren   = gnt_rd & ~rst;
    mem_wen   = gnt_wr & ~rst;
    mem_raddr = mem_ren ? sel_addr : '0;
    mem_waddr = mem_wen ? sel_addr : '0;
    mem_wdata = mem_wen ? sel_wdata : '0;

    rsp_valid = '0;
    rsp_data  = '0;
    stall_num = '0;
    served    = 1'b0;
    hold      = 1'b0;
    out_vld   = tag_vld_p[MEM_LAT-1] & ~rst;
    for (int i = 0; i < NCORES; i++) begin
      if (out_vld && tag_id_p[MEM_LAT-1] == IDW'(i)) begin
        rsp_valid[i]        = 1'b1;
        rsp_data[16*i +: 16] = mem_rdata;
      end
      served = gnt_vld && (gnt_idx == IDW'(i)) && !rd_left;
      hold   = (want[i] && !served) || pending[i];
      stall_num[3*i +: 3] = (hold && !rst) ? STALL_V : 3'd0;
    end
  end

  // Control state: pointer, rd+wr bookkeeping and tag valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      wr_done <= '0;
      for (int s = 0; s < MEM_LAT; s++) tag_vld_p[s] <= 1'b0;
    end else begin
      if (gnt_vld) rr_ptr <= rd_left ? gnt_idx : next_idx(gnt_idx);
      wr_done <= wr_done & req_rd;
      if (rd_left) wr_done[gnt_idx] <= 1'b1;
      if (gnt_rd)  wr_done[gnt_idx] <= 1'b0;
      tag_vld_p[0] <= gnt_rd;
      for (int s = 1; s < MEM_LAT; s++) tag_vld_p[s] <= tag_vld_p[s-1];
    end
  end

  // Tag ids ride alongside the valid bits; they are only looked at when valid.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= gnt_idx;
    for (int s = 1; s < MEM_LAT; s++) tag_id_p[s] <= tag_id_p[s-1];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three cores and a two-cycle memory model.
module tb_mem_port_arbiter;
  localparam int NC  = 3;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NC-1:0]  req_rd = '0, req_wr = '0;
  logic [NC*15-1:0] req_addr = '0;
  logic [NC*16-1:0] req_wdata = '0;
  logic [NC*3-1:0]  stall_num;
  logic [NC-1:0]  rsp_valid;
  logic [NC*16-1:0] rsp_data;
  logic           mem_ren, mem_wen;
  logic [14:0]    mem_raddr, mem_waddr;
  logic [15:0]    mem_rdata, mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NCORES(NC), .MEM_LAT(LAT), .STALL_STAGE(6)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall_num(stall_num), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Memory model: unwritten words read as BEEF at 0x10, else {a, ~a}.
  logic [15:0]  mem [256];
  logic [255:0] mem_ok = '0;
  logic [15:0]  rd_q1 = '0, rd_q2 = '0;

  function automatic logic [15:0] mem_init(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr[7:0]]    <= mem_wdata;
      mem_ok[mem_waddr[7:0]] <= 1'b1;
    end
    rd_q1 <= !mem_ren ? 16'h0 :
             (mem_ok[mem_raddr[7:0]] ? mem[mem_raddr[7:0]] : mem_init(mem_raddr[7:0]));
    rd_q2 <= rd_q1;
  end
  assign mem_rdata = rd_q2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req_rd = '0; req_wr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_rd = 3'b001; req_wr = 3'b010; req_addr[14:0] = 15'h10;
    tick(); tick();
    #4;
    n_checks++;
    if ({mem_ren, mem_wen} !== 2'b00) begin n_errors++; $display("FAIL rst_mem got %b want 00", {mem_ren, mem_wen}); end
    n_checks++;
    if (stall_num !== 9'o000) begin n_errors++; $display("FAIL rst_stall got %o want 000", stall_num); end
    n_checks++;
    if (rsp_valid !== 3'b000 || rsp_data !== '0) begin n_errors++; $display("FAIL rst_rsp got %b/%h want 0/0", rsp_valid, rsp_data); end
    tick();
    rst = 1'b0; req_rd = '0; req_wr = '0;
    tick();
  endtask

  task automatic test_single_read();
    req_rd = 3'b001; req_addr[14:0] = 15'h10;
    #4;
    n_checks++;
    if (mem_ren !== 1'b1 || mem_raddr !== 15'h10) begin n_errors++; $display("FAIL rd_grant got %b/%h want 1/0010", mem_ren, mem_raddr); end
    n_checks++;
    if (stall_num !== 9'o000) begin n_errors++; $display("FAIL rd_stall_t got %o want 000", stall_num); end
    tick();
    req_rd = '0;
    #4;
    n_checks++;
    if (stall_num !== 9'o006) begin n_errors++; $display("FAIL rd_stall_t1 got %o want 006", stall_num); end
    n_checks++;
    if (rsp_valid !== 3'b000) begin n_errors++; $display("FAIL rd_early_rsp got %b want 000", rsp_valid); end
    tick();
    #4;
    n_checks++;
    if (rsp_valid !== 3'b001 || rsp_data[15:0] !== 16'hBEEF) begin n_errors++; $display("FAIL rd_rsp got %b/%h want 001/beef", rsp_valid, rsp_data[15:0]); end
    n_checks++;
    if (stall_num !== 9'o000) begin n_errors++; $display("FAIL rd_stall_t2 got %o want 000", stall_num); end
    tick();
    #4;
    n_checks++;
    if (rsp_valid !== 3'b000) begin n_errors++; $display("FAIL rd_one_pulse got %b want 000", rsp_valid); end
    tick();
  endtask

  task automatic test_two_stores();
    pulse_reset();
    req_wr = 3'b011;
    req_addr[14:0] = 15'h30; req_wdata[15:0]  = 16'h1111;
    req_addr[29:15] = 15'h31; req_wdata[31:16] = 16'h2222;
    #4;
    n_checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_waddr !== 15'h30 || mem_wdata !== 16'h1111) begin
      n_errors++; $display("FAIL st_core0 got %b%b %h %h want 10 0030 1111", mem_wen, mem_ren, mem_waddr, mem_wdata);
    end
    n_checks++;
    if (stall_num !== 9'o060) begin n_errors++; $display("FAIL st_stall_t got %o want 060", stall_num); end
    tick();
    req_wr = 3'b010;
    #4;
    n_checks++;
    if (mem_wen !== 1'b1 || mem_waddr !== 15'h31 || mem_wdata !== 16'h2222) begin
      n_errors++; $display("FAIL st_core1 got %b %h %h want 1 0031 2222", mem_wen, mem_waddr, mem_wdata);
    end
    n_checks++;
    if (stall_num !== 9'o000) begin n_errors++; $display("FAIL st_stall_t1 got %o want 000", stall_num); end
    tick();
    req_wr = '0;
  endtask

  task automatic test_round_robin();
    logic [14:0] exp_addr [6];
    logic [2:0]  exp_rsp [8];
    logic [8:0]  exp_stall [8];
    logic [15:0] exp_data [3];
    int          pulses [3];
    exp_addr  = '{15'h40, 15'h41, 15'h42, 15'h40, 15'h41, 15'h42};
    exp_rsp   = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_stall = '{9'o660, 9'o606, 9'o066, 9'o660, 9'o606, 9'o066, 9'o600, 9'o000};
    exp_data  = '{16'h40BF, 16'h41BE, 16'h42BD};
    pulses    = '{0, 0, 0};
    pulse_reset();
    req_addr = {15'h42, 15'h41, 15'h40};
    for (int c = 0; c < 8; c++) begin
      req_rd = (c < 6) ? 3'b111 : 3'b000;
      #4;
      if (c < 6) begin
        n_checks++;
        if (mem_ren !== 1'b1 || mem_raddr !== exp_addr[c]) begin
          n_errors++; $display("FAIL rr_grant%0d got %b/%h want 1/%h", c, mem_ren, mem_raddr, exp_addr[c]);
        end
      end
      n_checks++;
      if (rsp_valid !== exp_rsp[c]) begin n_errors++; $display("FAIL rr_rsp%0d got %b want %b", c, rsp_valid, exp_rsp[c]); end
      n_checks++;
      if (stall_num !== exp_stall[c]) begin n_errors++; $display("FAIL rr_stall%0d got %o want %o", c, stall_num, exp_stall[c]); end
      for (int i = 0; i < 3; i++)
        if (rsp_valid[i]) begin
          pulses[i]++;
          n_checks++;
          if (rsp_data[16*i +: 16] !== exp_data[i]) begin
            n_errors++; $display("FAIL rr_data%0d_core%0d got %h want %h", c, i, rsp_data[16*i +: 16], exp_data[i]);
          end
        end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pulses[i] != 2) begin n_errors++; $display("FAIL rr_pulses_core%0d got %0d want 2", i, pulses[i]); end
    end
  endtask

  task automatic test_rd_wr_same();
    req_rd = 3'b010; req_wr = 3'b010;
    req_addr[29:15] = 15'h20; req_wdata[31:16] = 16'h1234;
    #4;
    n_checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_waddr !== 15'h20 || mem_wdata !== 16'h1234) begin
      n_errors++; $display("FAIL rw_write got %b%b %h %h want 10 0020 1234", mem_wen, mem_ren, mem_waddr, mem_wdata);
    end
    tick();
    #4;
    n_checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_raddr !== 15'h20) begin
      n_errors++; $display("FAIL rw_read got %b%b %h want 10 0020", mem_ren, mem_wen, mem_raddr);
    end
    tick();
    req_rd = '0; req_wr = '0;
    #4;
    n_checks++;
    if (stall_num !== 9'o060) begin n_errors++; $display("FAIL rw_stall got %o want 060", stall_num); end
    tick();
    #4;
    n_checks++;
    if (rsp_valid !== 3'b010 || rsp_data[31:16] !== 16'h1234) begin
      n_errors++; $display("FAIL rw_data got %b/%h want 010/1234", rsp_valid, rsp_data[31:16]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_rd = 3'b001; req_addr[14:0] = 15'h10; req_addr[44:30] = 15'h55;
    #4;
    n_checks++;
    if (mem_ren !== 1'b1) begin n_errors++; $display("FAIL rm_grant got %b want 1", mem_ren); end
    tick();
    req_rd = '0; rst = 1'b1;
    #4;
    n_checks++;
    if (stall_num !== 9'o000 || rsp_valid !== 3'b000) begin n_errors++; $display("FAIL rm_in_rst got %o/%b want 000/000", stall_num, rsp_valid); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      n_checks++;
      if (rsp_valid !== 3'b000 || stall_num !== 9'o000) begin
        n_errors++; $display("FAIL rm_after%0d got %b/%o want 000/000", c, rsp_valid, stall_num);
      end
      tick();
    end
    req_rd = 3'b101;
    #4;
    n_checks++;
    if (mem_raddr !== 15'h10) begin n_errors++; $display("FAIL rm_ptr got %h want 0010", mem_raddr); end
    tick();
    req_rd = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      #4;
      n_checks++;
      if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || stall_num !== 9'o000 || rsp_valid !== 3'b000) begin
        n_errors++; $display("FAIL idle%0d got %b%b %o %b want 00 000 000", c, mem_ren, mem_wen, stall_num, rsp_valid);
      end
      tick();
    end
    req_rd = 3'b101;
    #4;
    n_checks++;
    if (mem_raddr !== 15'h55) begin n_errors++; $display("FAIL idle_ptr got %h want 0055", mem_raddr); end
    tick();
    req_rd = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_single_read();
    test_two_stores();
    test_round_robin();
    test_rd_wr_same();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
